data_bus_arbiter: RTL and testbench

//  Shares one single-port data RAM between two bus masters: M0 = RV32I core data port
//  (dataWe/dataAddr/dataWData/dataRData), M1 = external master (boot loader / DMA).
//  Req/ready handshake, round-robin arbitration, one transaction in flight at a time.

---
 rtl/data_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM, one access in flight.
// Optional M1 bus lock with a bounded grant streak, enabled by defining ARB_LOCK_EN.
module data_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              slave_en,
  output logic              slave_we,
  output logic [ADDR_W-1:0] slave_addr,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic [DATA_W-1:0] slave_rdata,
  output logic              owner,
  output logic              busy
);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  logic              r_last_owner;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_slave_en;
  logic              r_slave_we;
  logic              r_m0_ready;
  logic              r_m1_ready;

  logic w_any;
  logic w_win;
  logic w_lock_win;

  assign w_any = m0_req | m1_req;

  always_comb begin
    w_win = 1'b0;
    if (w_lock_win)          w_win = 1'b1;
    else if (m0_req & m1_req) w_win = ~r_last_owner;
    else                     w_win = m1_req;
  end

`ifdef ARB_LOCK_EN
  logic [LOCK_W-1:0] r_lock_cnt;

  assign w_lock_win = r_last_owner & m1_req & m1_lock & (r_lock_cnt < LOCK_W'(LOCK_MAX));

  // Any M1 grant taken while locked extends the streak; saturates so a lone M1 cannot wrap it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        if (w_win & m1_lock) begin
          if (r_lock_cnt < LOCK_W'(LOCK_MAX)) r_lock_cnt <= r_lock_cnt + 1'b1;
        end else begin
          r_lock_cnt <= '0;
        end
      end else if (!m1_lock) begin
        r_lock_cnt <= '0;
      end
    end
  end
`else
  logic [LOCK_W:0] w_unused;
  assign w_lock_win = 1'b0;
  assign w_unused   = {m1_lock, {LOCK_W{1'b0}}};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_slave_en   <= 1'b0;
      r_slave_we   <= 1'b0;
      r_m0_ready   <= 1'b0;
      r_m1_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner    <= w_win;
            r_we       <= w_win ? m1_we    : m0_we;
            r_addr     <= w_win ? m1_addr  : m0_addr;
            r_wdata    <= w_win ? m1_wdata : m0_wdata;
            r_slave_en <= 1'b1;
            r_slave_we <= w_win ? m1_we    : m0_we;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_slave_en <= 1'b0;
          r_slave_we <= 1'b0;
          r_m0_ready <= ~r_owner;
          r_m1_ready <= r_owner;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_m0_ready   <= 1'b0;
          r_m1_ready   <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM read data arrives the cycle after the strobe, so it is passed straight through in RESP.
  assign m0_rdata    = (r_m0_ready & ~r_we) ? slave_rdata : '0;
  assign m1_rdata    = (r_m1_ready & ~r_we) ? slave_rdata : '0;
  assign m0_ready    = r_m0_ready;
  assign m1_ready    = r_m1_ready;
  assign slave_en    = r_slave_en;
  assign slave_we    = r_slave_we;
  assign slave_addr  = r_addr;
  assign slave_wdata = r_wdata;
  assign owner       = r_owner;
  assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Transaction-level reference model (winner rule + memory image) against data_bus_arbiter.
// Honours ARB_LOCK_EN when the design is built with it.
module tb_data_bus_arbiter;
  localparam int LMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        slave_en, slave_we;
  logic [31:0] slave_addr, slave_wdata;
  logic [31:0] slave_rdata;
  logic        owner, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [256];
  logic        ram_init;
  logic [31:0] exp_mem [256];
  bit          m_last;
  int          m_cnt;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
    .slave_en(slave_en), .slave_we(slave_we), .slave_addr(slave_addr),
    .slave_wdata(slave_wdata), .slave_rdata(slave_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM device: synchronous read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[8'h10]  <= 32'hDEADBEEF;
      slave_rdata <= 32'h0;
    end else if (slave_en) begin
      if (slave_we) ram[slave_addr[7:0]] <= slave_wdata;
      slave_rdata <= ram[slave_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic txn(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                     input bit lk, input bit drop);
    bit          win, lockwin, ewe;
    logic [31:0] ea, ed, erd;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    lockwin = 1'b0;
`ifdef ARB_LOCK_EN
    lockwin = m_last && r1 && lk && (m_cnt < LMAX);
`endif
    win = lockwin ? 1'b1 : ((r0 && r1) ? !m_last : r1);
`ifdef ARB_LOCK_EN
    if (r0 || r1) m_cnt = (win && lk) ? ((m_cnt < LMAX) ? m_cnt + 1 : m_cnt) : 0;
    else if (!lk) m_cnt = 0;
`endif
    @(posedge clk); @(negedge clk);
    if (!(r0 || r1)) begin
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_en", {31'b0, slave_en}, 32'h0);
      return;
    end
    ewe = win ? w1 : w0;
    ea  = win ? a1 : a0;
    ed  = win ? d1 : d0;
    erd = ewe ? 32'h0 : exp_mem[ea[7:0]];
    chk("acc_en",    {31'b0, slave_en}, 32'h1);
    chk("acc_we",    {31'b0, slave_we}, {31'b0, ewe});
    chk("acc_addr",  slave_addr, ea);
    chk("acc_wdata", slave_wdata, ed);
    chk("acc_owner", {31'b0, owner}, {31'b0, win});
    chk("acc_busy",  {31'b0, busy}, 32'h1);
    chk("acc_rdy",   {30'b0, m1_ready, m0_ready}, 32'h0);
    if (drop) begin
      if (win) begin m1_req = 1'b0; m1_addr = $urandom; end
      else     begin m0_req = 1'b0; m0_addr = $urandom; end
    end
    @(posedge clk); @(negedge clk);
    chk("rsp_en",    {30'b0, slave_we, slave_en}, 32'h0);
    chk("rsp_rdy0",  {31'b0, m0_ready}, {31'b0, !win});
    chk("rsp_rdy1",  {31'b0, m1_ready}, {31'b0, win});
    chk("rsp_rd0",   m0_rdata, win ? 32'h0 : erd);
    chk("rsp_rd1",   m1_rdata, win ? erd : 32'h0);
    chk("rsp_addr",  slave_addr, ea);
    chk("rsp_busy",  {31'b0, busy}, 32'h1);
    if (ewe) exp_mem[ea[7:0]] = ed;
    m_last = win;
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idl_busy",  {31'b0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; ram_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    exp_mem[8'h10] = 32'hDEADBEEF;
    m_last = 1'b1; m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_en",    {30'b0, slave_we, slave_en}, 32'h0);
    chk("rst_addr",  slave_addr, 32'h0);
    chk("rst_wdata", slave_wdata, 32'h0);
    chk("rst_rdy",   {30'b0, m1_ready, m0_ready}, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_owner", {31'b0, owner}, 32'h0);
    reset = 1'b1; ram_init = 1'b0;
    @(negedge clk);

    // reset asserted while an M1 access is on the bus
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    chk("pre_en", {31'b0, slave_en}, 32'h1);
    reset = 1'b0; #1;
    chk("mid_en",    {31'b0, slave_en}, 32'h0);
    chk("mid_busy",  {31'b0, busy}, 32'h0);
    chk("mid_rdy",   {30'b0, m1_ready, m0_ready}, 32'h0);
    chk("mid_owner", {31'b0, owner}, 32'h0);
    m1_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    m_last = 1'b1; m_cnt = 0;
    @(negedge clk);

    // tie after reset goes to M0; then M0 reads the preloaded word
    txn(1, 0, 32'h40, 0, 1, 0, 32'h44, 0, 0, 0);
    txn(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 0, 32'h00, 0, 0, 0);
    // same-cycle read/write to one address, then read back
    txn(1, 0, 32'h20, 0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 0);
    txn(0, 0, 0, 0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 0);
    txn(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    // request dropped mid-access, no extra grant afterwards
    txn(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 1);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // both masters continuously requesting
    for (int i = 0; i < 6; i++)
      txn(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), $urandom,
          1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), $urandom, 0, 0);
    // lock held from an M1-owner state
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 0, 32'h08, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      txn(1, 0, 32'h0C, 0, 1, 0, 32'h10, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 60; i++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), $urandom,
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
